// File: rtl/multicycle_controller.sv
//------------------------------------------------------------------------------
// Module   : multicycle_controller
// Brief    : Moore sequencer stepping MIPS instructions through fetch..write-back.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_iord,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_mem_to_reg,
  output logic             o_reg_dst,
  output logic             o_reg_write,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_pc_source,
  output logic [3:0]       o_state,
  output logic             o_illegal_op,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  // Per-state control word; the in_* flags qualify the outputs that also
  // depend on same-cycle inputs (mem_ready, zero, opcode).
  typedef struct packed {
    logic       in_fetch;
    logic       in_decode;
    logic       in_branch;
    logic       in_jump;
    logic       retire;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.in_fetch  = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        c.in_decode = 1'b1;
        c.alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.retire    = 1'b1;
      end
      S_BRANCH: begin
        c.in_branch = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_source = 2'b01;
        c.retire    = 1'b1;
      end
      S_JUMP: begin
        c.in_jump   = 1'b1;
        c.pc_source = 2'b10;
        c.retire    = 1'b1;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           r_state;
  state_t           w_next;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_retired;
  logic             w_supported;
  logic             w_branch_taken;
  logic             w_retire;
  logic             w_run;

  always_comb begin
    w_supported = 1'b0;
    case (i_opcode)
      c_OP_RTYPE, c_OP_LW, c_OP_SW, c_OP_BEQ,
      c_OP_BNE, c_OP_J, c_OP_ADDI: w_supported = 1'b1;
      default:                     w_supported = 1'b0;
    endcase
  end

  assign w_branch_taken = ((i_opcode == c_OP_BEQ) &  i_zero) |
                          ((i_opcode == c_OP_BNE) & ~i_zero);

  // A store retires on the cycle its write is accepted, not on entry.
  assign w_retire = r_ctrl.retire | (r_ctrl.mem_write & i_mem_ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          c_OP_LW, c_OP_SW:   w_next = S_MEM_ADDR;
          c_OP_RTYPE:         w_next = S_R_EXEC;
          c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
          c_OP_J:             w_next = S_JUMP;
          c_OP_ADDI:          w_next = S_ADDI_EXEC;
          default:            w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next = (i_opcode == c_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = i_mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = i_mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_ADDI_WB:   w_next = S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  // The control word is registered from the next state so it always matches r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decode_state(S_FETCH);
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_state(w_next);
      if (w_retire) begin
        r_retired <= r_retired + c_ONE;
      end
    end
  end

  // Reset masks every control output immediately, whatever the state.
  assign w_run = ~reset;

  assign o_iord       = w_run & r_ctrl.iord;
  assign o_mem_read   = w_run & r_ctrl.mem_read;
  assign o_mem_write  = w_run & r_ctrl.mem_write;
  assign o_mem_to_reg = w_run & r_ctrl.mem_to_reg;
  assign o_reg_dst    = w_run & r_ctrl.reg_dst;
  assign o_reg_write  = w_run & r_ctrl.reg_write;
  assign o_alu_src_a  = w_run & r_ctrl.alu_src_a;
  assign o_alu_src_b  = {2{w_run}} & r_ctrl.alu_src_b;
  assign o_alu_op     = {2{w_run}} & r_ctrl.alu_op;
  assign o_pc_source  = {2{w_run}} & r_ctrl.pc_source;
  assign o_ir_write   = w_run & r_ctrl.in_fetch & i_mem_ready;
  assign o_pc_write   = w_run & ((r_ctrl.in_fetch & i_mem_ready) |
                                 r_ctrl.in_jump |
                                 (r_ctrl.in_branch & w_branch_taken));
  assign o_illegal_op = w_run & r_ctrl.in_decode & ~w_supported;
  assign o_state      = r_state;
  assign o_retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_multicycle_controller
// Brief    : Vector table plus retired-count scoreboard for multicycle_controller.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] i_opcode;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_pc_write, o_iord, o_mem_read, o_mem_write, o_ir_write;
  logic       o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a;
  logic [1:0] o_alu_src_b, o_alu_op, o_pc_source;
  logic [3:0] o_state;
  logic       o_illegal_op;
  logic [3:0] o_retired;

  multicycle_controller #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_opcode     (i_opcode),
    .i_zero       (i_zero),
    .i_mem_ready  (i_mem_ready),
    .o_pc_write   (o_pc_write),
    .o_iord       (o_iord),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_ir_write   (o_ir_write),
    .o_mem_to_reg (o_mem_to_reg),
    .o_reg_dst    (o_reg_dst),
    .o_reg_write  (o_reg_write),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_op     (o_alu_op),
    .o_pc_source  (o_pc_source),
    .o_state      (o_state),
    .o_illegal_op (o_illegal_op),
    .o_retired    (o_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic [15:0] rdy;   // mem_ready per cycle, bit k = cycle k
    logic [63:0] seq;   // expected state per cycle, nibble k = cycle k
    int          len;
    int          inc;
    logic        pcw;   // expected pc_write in BRANCH
    logic        ill;
  } vec_t;

  vec_t       tbl[13];
  vec_t       v_jump;
  int         n_checks;
  int         n_err;
  logic [3:0] m_ret;
  logic [3:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ctrl_bus();
    return {o_pc_write, o_iord, o_mem_read, o_mem_write, o_ir_write, o_mem_to_reg,
            o_reg_dst, o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_source};
  endfunction

  // Call just after a rising edge with the DUT in FETCH.
  task automatic run_vec(input vec_t v);
    logic [3:0] st;
    logic       rdy;
    m_ret = m_ret + 4'(v.inc);
    sb_q.push_back(m_ret);
    for (int k = 0; k < v.len; k++) begin
      i_opcode    = v.op;
      i_zero      = v.zero;
      i_mem_ready = v.rdy[k];
      rdy         = v.rdy[k];
      st          = v.seq[4*k +: 4];
      @(negedge clk);
      check("state", 32'(o_state), 32'(st));
      check("illegal_op", 32'(o_illegal_op), 32'(v.ill && st == 4'd1));
      check("ir_write", 32'(o_ir_write), 32'(st == 4'd0 && rdy));
      check("pc_write", 32'(o_pc_write),
            32'((st == 4'd0 && rdy) || st == 4'd9 || (st == 4'd8 && v.pcw)));
      check("mem_read", 32'(o_mem_read), 32'(st == 4'd0 || st == 4'd3));
      check("mem_write", 32'(o_mem_write), 32'(st == 4'd5));
      check("iord", 32'(o_iord), 32'(st == 4'd3 || st == 4'd5));
      check("reg_write", 32'(o_reg_write), 32'(st == 4'd4 || st == 4'd7 || st == 4'd11));
      check("reg_dst", 32'(o_reg_dst), 32'(st == 4'd7));
      if (st == 4'd8) check("pc_source_br", 32'(o_pc_source), 32'd1);
      @(posedge clk);
      #1;
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check("retired", 32'(o_retired), 32'(sb_q.pop_front()));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    m_ret    = 4'd0;

    //            op          z     rdy       seq               len inc pcw  ill
    tbl[0]  = '{6'b000000, 1'b0, 16'hFFFF, 64'h7610,          4, 1, 1'b0, 1'b0};
    tbl[1]  = '{6'b100011, 1'b0, 16'hFFFF, 64'h43210,         5, 1, 1'b0, 1'b0};
    tbl[2]  = '{6'b100011, 1'b0, 16'hFFC7, 64'h43333210,      8, 1, 1'b0, 1'b0};
    tbl[3]  = '{6'b101011, 1'b0, 16'hFFFF, 64'h5210,          4, 1, 1'b0, 1'b0};
    tbl[4]  = '{6'b101011, 1'b0, 16'hFFFC, 64'h521000,        6, 1, 1'b0, 1'b0};
    tbl[5]  = '{6'b001000, 1'b0, 16'hFFFF, 64'hBA10,          4, 1, 1'b0, 1'b0};
    tbl[6]  = '{6'b000100, 1'b1, 16'hFFFF, 64'h810,           3, 1, 1'b1, 1'b0};
    tbl[7]  = '{6'b000100, 1'b0, 16'hFFFF, 64'h810,           3, 1, 1'b0, 1'b0};
    tbl[8]  = '{6'b000101, 1'b1, 16'hFFFF, 64'h810,           3, 1, 1'b0, 1'b0};
    tbl[9]  = '{6'b000101, 1'b0, 16'hFFFF, 64'h810,           3, 1, 1'b1, 1'b0};
    tbl[10] = '{6'b000010, 1'b0, 16'hFFFF, 64'h910,           3, 1, 1'b0, 1'b0};
    tbl[11] = '{6'b111111, 1'b0, 16'hFFFF, 64'h10,            2, 0, 1'b0, 1'b1};
    tbl[12] = '{6'b001101, 1'b0, 16'hFFFF, 64'h10,            2, 0, 1'b0, 1'b1};
    v_jump  = tbl[10];

    // Controls must be masked during reset even with mem_ready high.
    reset       = 1'b1;
    i_opcode    = 6'b000000;
    i_zero      = 1'b1;
    i_mem_ready = 1'b1;
    #3;
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_ctrl", 32'(ctrl_bus()), 32'd0);
    check("rst_retired", 32'(o_retired), 32'd0);
    check("rst_illegal", 32'(o_illegal_op), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset arriving mid R_EXEC aborts the instruction and clears the count.
    i_opcode    = 6'b000000;
    i_mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rexec_state", 32'(o_state), 32'd6);
    check("rexec_alu_op", 32'(o_alu_op), 32'd2);
    check("rexec_src_a", 32'(o_alu_src_a), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_state", 32'(o_state), 32'd0);
    check("async_ctrl", 32'(ctrl_bus()), 32'd0);
    check("async_retired", 32'(o_retired), 32'd0);
    m_ret = 4'd0;
    sb_q.delete();
    @(posedge clk);
    #1;
    reset       = 1'b0;
    i_mem_ready = 1'b0;
    @(negedge clk);
    check("rel_state", 32'(o_state), 32'd0);
    check("rel_mem_read", 32'(o_mem_read), 32'd1);
    check("rel_alu_src_b", 32'(o_alu_src_b), 32'd1);
    check("rel_ir_write", 32'(o_ir_write), 32'd0);
    @(posedge clk);
    #1;
    check("rel_stall_state", 32'(o_state), 32'd0);

    // Counter wrap: 15 jumps reach all-ones, the 16th wraps to zero.
    for (int n = 0; n < 15; n++) run_vec(v_jump);
    check("wrap_pre", 32'(o_retired), 32'd15);
    run_vec(v_jump);
    check("wrap_zero", 32'(o_retired), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the MIPS datapath (instruction memory, register file, ALU control, ALU). Replaces the single-cycle control decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, stalls on a memory ready handshake, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- opcode  in  6  instruction[31:26] from IR; stable from DECODE until next FETCH completes
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  load PC
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- mem_to_reg  out  1  reg write data: 0=ALUOut, 1=MDR
- reg_dst  out  1  dest: 0=rt, 1=rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A reg
- alu_src_b  out  2  00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct field
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state encoding
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- retired  out  CNT_W  retired-instruction count

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000.
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11. Codes 12-15 unreachable; if entered, next state FETCH.
- Outputs are decoded from state only (plus mem_ready/zero/opcode where noted); any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay while mem_ready=0, else DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). Next: lw/sw->MEM_ADDR, R->R_EXEC, beq/bne->BRANCH, j->JUMP, addi->ADDI_EXEC, other->FETCH with illegal_op=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, iord=1. Stay until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WRITE: mem_write=1, iord=1. Stay until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write = (beq & zero) | (bne & ~zero). Next FETCH.
- JUMP: pc_source=10, pc_write=1. Next FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- retired increments by 1 on the clock edge leaving MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, or MEM_WRITE with mem_ready=1; wraps modulo 2^CNT_W. Illegal opcodes not counted. Branches count whether taken or not.

## Timing
- reset asserted: state=FETCH immediately (asynchronous), retired=0, illegal_op=0, and all control outputs forced 0 regardless of state. First FETCH outputs appear in the cycle after reset deasserts.
- Reset mid-instruction aborts it; no count, no pending write completes.
- Cycles per instruction with mem_ready held 1: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3, illegal 2. Each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one.
- mem_read/mem_write held constant through a stall; ir_write/pc_write in FETCH only in the mem_ready=1 cycle.
- State register and retired update on rising clk only.

## Test plan
- Reset mid-R_EXEC: assert reset async -> state=0, all controls 0, retired=0 same cycle; release -> FETCH with mem_read=1 next cycle.
- R-type (opcode 0), mem_ready=1: states 0,1,6,7,0; reg_write=1 & reg_dst=1 only in state 7; retired 0->1 after 4 cycles.
- lw with mem_ready=0 for 3 cycles in MEM_READ: states 0,1,2,3,3,3,3,4,0; iord=1 and mem_read=1 steady in state 3; total 8 cycles.
- beq with zero=1 -> pc_write=1, pc_source=01 in BRANCH; bne with zero=1 -> pc_write=0; both increment retired.
- Opcode 111111: DECODE pulses illegal_op for one cycle, returns to FETCH, retired unchanged.
- Preload retired=2^CNT_W-1 (via CNT_W=4, 15 instructions), run j -> retired wraps to 0.
